// File: rtl/wb_pkg.sv
// Shared Wishbone decoder types: FSM states and fault codes.
package wb_pkg;

  localparam int WB_FAULT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    ERR  = 2'b10
  } wb_state_t;

  typedef enum logic [WB_FAULT_W-1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_UNMAPPED = 2'b01,
    FAULT_TIMEOUT  = 2'b10
  } fault_code_t;

endpackage

// File: rtl/wb_watchdog.sv
// Saturating stall counter; expired is high once TIMEOUT enabled cycles have elapsed.
module wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_r;

  // Count enabled cycles, holding at LIMIT so the counter never wraps
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && (cnt_r != LIMIT)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // A zero TIMEOUT leaves LIMIT at the reset value, so gate it off explicitly
  assign expired = (TIMEOUT != 0) && (cnt_r == LIMIT);

endmodule

// File: rtl/wb_decoder.sv
// Wishbone address decoder: one master to 2^SEL_W slave ports with registered
// port decode, unmapped-port errors and a stall watchdog.
module wb_decoder
  import wb_pkg::*;
#(
  parameter int                      AW        = 32,
  parameter int                      DW        = 32,
  parameter int                      SEL_LSB   = 28,
  parameter int                      SEL_W     = 4,
  parameter logic [(1<<SEL_W)-1:0]   PORT_MASK = '1,
  parameter int                      TIMEOUT   = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          m_cyc,
  input  logic                          m_stb,
  input  logic                          m_we,
  input  logic [AW-1:0]                 m_adr,
  input  logic [DW/8-1:0]               m_sel,
  input  logic [DW-1:0]                 m_dat_o,
  output logic [DW-1:0]                 m_dat_i,
  output logic                          m_ack,
  output logic                          m_err,
  output logic [(1<<SEL_W)-1:0]         s_cyc,
  output logic [(1<<SEL_W)-1:0]         s_stb,
  output logic                          s_we,
  output logic [AW-1:0]                 s_adr,
  output logic [DW/8-1:0]               s_sel,
  output logic [DW-1:0]                 s_dat_o,
  input  logic [(1<<SEL_W)*DW-1:0]      s_dat_i,
  input  logic [(1<<SEL_W)-1:0]         s_ack,
  output logic                          fault,
  output logic [WB_FAULT_W-1:0]         fault_code,
  output logic [AW-1:0]                 fault_adr
);

  wb_state_t   state_r;
  logic [SEL_W-1:0] port_r;
  logic [AW-1:0]    adr_r;
  logic             m_err_r;
  logic             fault_r;
  fault_code_t      fault_code_r;
  logic [AW-1:0]    fault_adr_r;

  logic [SEL_W-1:0] idx_s;
  logic             req_s;
  logic             ack_s;
  logic             busy_s;
  logic             expired_s;

  assign idx_s  = m_adr[SEL_LSB +: SEL_W];
  assign req_s  = m_cyc & m_stb;
  assign busy_s = (state_r == BUSY);
  assign ack_s  = s_ack[port_r];

  assign s_we    = m_we;
  assign s_adr   = m_adr;
  assign s_sel   = m_sel;
  assign s_dat_o = m_dat_o;

  assign m_err      = m_err_r;
  assign fault      = fault_r;
  assign fault_code = fault_code_r;
  assign fault_adr  = fault_adr_r;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (state_r == IDLE),
    .en      (busy_s & ~ack_s),
    .expired (expired_s)
  );

  // Decode FSM; m_err and fault are registered so they rise together on ERR entry
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r      <= IDLE;
      port_r       <= '0;
      adr_r        <= '0;
      m_err_r      <= 1'b0;
      fault_r      <= 1'b0;
      fault_code_r <= FAULT_NONE;
      fault_adr_r  <= '0;
    end else begin
      m_err_r <= 1'b0;
      fault_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_s) begin
            if (PORT_MASK[idx_s]) begin
              port_r  <= idx_s;
              adr_r   <= m_adr;
              state_r <= BUSY;
            end else begin
              state_r      <= ERR;
              m_err_r      <= 1'b1;
              fault_r      <= 1'b1;
              fault_code_r <= FAULT_UNMAPPED;
              fault_adr_r  <= m_adr;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          // Ack and master abort both outrank a watchdog expiry in the same cycle
          if (ack_s || !m_cyc) begin
            state_r <= IDLE;
          end else if (expired_s) begin
            state_r      <= ERR;
            m_err_r      <= 1'b1;
            fault_r      <= 1'b1;
            fault_code_r <= FAULT_TIMEOUT;
            fault_adr_r  <= adr_r;
          end else begin
            state_r <= BUSY;
          end
        end
        ERR: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Route the selected port's strobes and return path only while BUSY
  always_comb begin
    s_cyc   = '0;
    s_stb   = '0;
    m_ack   = 1'b0;
    m_dat_i = '0;
    if (busy_s) begin
      s_cyc[port_r] = m_cyc;
      s_stb[port_r] = m_stb;
      m_ack         = ack_s;
      m_dat_i       = s_dat_i[port_r*DW +: DW];
    end else begin
      m_ack = 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_decoder.sv
// Directed bench for wb_decoder: a default instance and a sparse-map/short-timeout instance.
module tb_wb_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // Instance A: defaults (SEL_LSB=28, all ports, TIMEOUT=255)
  logic        a_cyc, a_stb, a_we, a_ack, a_err, a_s_we, a_fault;
  logic [31:0] a_adr, a_wdat, a_rdat, a_s_adr, a_s_dat_o, a_fadr;
  logic [3:0]  a_sel, a_s_sel;
  logic [15:0] a_s_cyc, a_s_stb, a_s_ack;
  logic [511:0] a_s_dat_i;
  logic [1:0]  a_fcode;

  // Instance B: SEL_LSB=12, ports 5/7/8 populated, TIMEOUT=8
  logic        b_cyc, b_stb, b_we, b_ack, b_err, b_s_we, b_fault;
  logic [31:0] b_adr, b_wdat, b_rdat, b_s_adr, b_s_dat_o, b_fadr;
  logic [3:0]  b_sel, b_s_sel;
  logic [15:0] b_s_cyc, b_s_stb, b_s_ack;
  logic [511:0] b_s_dat_i;
  logic [1:0]  b_fcode;

  wb_decoder dut_a (
    .clk_i(clk), .rst_i(rst_n),
    .m_cyc(a_cyc), .m_stb(a_stb), .m_we(a_we), .m_adr(a_adr), .m_sel(a_sel),
    .m_dat_o(a_wdat), .m_dat_i(a_rdat), .m_ack(a_ack), .m_err(a_err),
    .s_cyc(a_s_cyc), .s_stb(a_s_stb), .s_we(a_s_we), .s_adr(a_s_adr),
    .s_sel(a_s_sel), .s_dat_o(a_s_dat_o), .s_dat_i(a_s_dat_i), .s_ack(a_s_ack),
    .fault(a_fault), .fault_code(a_fcode), .fault_adr(a_fadr)
  );

  wb_decoder #(
    .SEL_LSB(12), .SEL_W(4), .PORT_MASK(16'h01A0), .TIMEOUT(8)
  ) dut_b (
    .clk_i(clk), .rst_i(rst_n),
    .m_cyc(b_cyc), .m_stb(b_stb), .m_we(b_we), .m_adr(b_adr), .m_sel(b_sel),
    .m_dat_o(b_wdat), .m_dat_i(b_rdat), .m_ack(b_ack), .m_err(b_err),
    .s_cyc(b_s_cyc), .s_stb(b_s_stb), .s_we(b_s_we), .s_adr(b_s_adr),
    .s_sel(b_s_sel), .s_dat_o(b_s_dat_o), .s_dat_i(b_s_dat_i), .s_ack(b_s_ack),
    .fault(b_fault), .fault_code(b_fcode), .fault_adr(b_fadr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    n_cmp++; if (a_s_cyc !== 16'h0000) begin n_bad++; $display("FAIL reset_s_cyc: got %h want 0000", a_s_cyc); end
    n_cmp++; if (a_s_stb !== 16'h0000) begin n_bad++; $display("FAIL reset_s_stb: got %h want 0000", a_s_stb); end
    n_cmp++; if ({a_ack, a_err, a_fault} !== 3'b000) begin n_bad++; $display("FAIL reset_ack_err_fault: got %b want 000", {a_ack, a_err, a_fault}); end
    n_cmp++; if (a_fcode !== 2'b00) begin n_bad++; $display("FAIL reset_fault_code: got %b want 00", a_fcode); end
    n_cmp++; if (a_fadr !== 32'h0000_0000) begin n_bad++; $display("FAIL reset_fault_adr: got %h want 00000000", a_fadr); end
    n_cmp++; if ({b_err, b_fault, b_fcode} !== 4'b0000) begin n_bad++; $display("FAIL reset_b_err_fault: got %b want 0000", {b_err, b_fault, b_fcode}); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_default;
    a_cyc = 1'b1; a_stb = 1'b1; a_we = 1'b0; a_adr = 32'h5000_0010; a_sel = 4'hF;
    #1;
    n_cmp++; if (a_s_stb !== 16'h0000) begin n_bad++; $display("FAIL read_c0_s_stb: got %h want 0000", a_s_stb); end
    n_cmp++; if (a_s_adr !== 32'h5000_0010) begin n_bad++; $display("FAIL read_s_adr: got %h want 50000010", a_s_adr); end
    tick();
    n_cmp++; if (a_s_stb !== 16'h0020) begin n_bad++; $display("FAIL read_c1_s_stb: got %h want 0020", a_s_stb); end
    n_cmp++; if (a_s_cyc !== 16'h0020) begin n_bad++; $display("FAIL read_c1_s_cyc: got %h want 0020", a_s_cyc); end
    n_cmp++; if (a_ack !== 1'b0) begin n_bad++; $display("FAIL read_c1_ack: got %b want 0", a_ack); end
    tick();
    a_s_ack = 16'h0020;
    #1;
    n_cmp++; if ({a_ack, a_err} !== 2'b10) begin n_bad++; $display("FAIL read_c2_ack_err: got %b want 10", {a_ack, a_err}); end
    n_cmp++; if (a_rdat !== 32'hD000_0005) begin n_bad++; $display("FAIL read_c2_data: got %h want d0000005", a_rdat); end
    tick();
    a_s_ack = 16'h0000; a_cyc = 1'b0; a_stb = 1'b0;
    #1;
    n_cmp++; if ({a_s_stb, a_ack} !== 17'h0) begin n_bad++; $display("FAIL read_c3_idle: got %h want 0", {a_s_stb, a_ack}); end
  endtask

  task automatic test_unmapped;
    b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b0; b_adr = 32'h3000_0000;
    #1;
    n_cmp++; if (b_s_stb !== 16'h0000) begin n_bad++; $display("FAIL unmap_c0_s_stb: got %h want 0000", b_s_stb); end
    tick();
    n_cmp++; if ({b_err, b_fault, b_ack} !== 3'b110) begin n_bad++; $display("FAIL unmap_c1_err_fault_ack: got %b want 110", {b_err, b_fault, b_ack}); end
    n_cmp++; if (b_fcode !== 2'b01) begin n_bad++; $display("FAIL unmap_fault_code: got %b want 01", b_fcode); end
    n_cmp++; if (b_fadr !== 32'h3000_0000) begin n_bad++; $display("FAIL unmap_fault_adr: got %h want 30000000", b_fadr); end
    n_cmp++; if (b_s_stb !== 16'h0000) begin n_bad++; $display("FAIL unmap_c1_s_stb: got %h want 0000", b_s_stb); end
    b_cyc = 1'b0; b_stb = 1'b0;
    tick();
    n_cmp++; if ({b_err, b_fault, b_s_stb} !== 18'h0) begin n_bad++; $display("FAIL unmap_c2_clear: got %h want 0", {b_err, b_fault, b_s_stb}); end
    n_cmp++; if (b_fcode !== 2'b01) begin n_bad++; $display("FAIL unmap_code_hold: got %b want 01", b_fcode); end
  endtask

  task automatic test_timeout;
    b_cyc = 1'b1; b_stb = 1'b1; b_adr = 32'h0000_7000;
    tick();
    for (int k = 1; k <= 9; k++) begin
      n_cmp++;
      if ({b_s_stb, b_err} !== {16'h0080, 1'b0}) begin
        n_bad++; $display("FAIL timeout_busy_c%0d: got stb=%h err=%b want stb=0080 err=0", k, b_s_stb, b_err);
      end
      if (k < 9) tick();
    end
    tick();
    n_cmp++; if ({b_err, b_fault, b_ack} !== 3'b110) begin n_bad++; $display("FAIL timeout_c10_err_fault_ack: got %b want 110", {b_err, b_fault, b_ack}); end
    n_cmp++; if (b_fcode !== 2'b10) begin n_bad++; $display("FAIL timeout_fault_code: got %b want 10", b_fcode); end
    n_cmp++; if (b_fadr !== 32'h0000_7000) begin n_bad++; $display("FAIL timeout_fault_adr: got %h want 00007000", b_fadr); end
    n_cmp++; if (b_s_stb !== 16'h0000) begin n_bad++; $display("FAIL timeout_err_s_stb: got %h want 0000", b_s_stb); end
    b_cyc = 1'b0; b_stb = 1'b0;
    tick();
    n_cmp++; if ({b_err, b_fault} !== 2'b00) begin n_bad++; $display("FAIL timeout_err_one_cycle: got %b want 00", {b_err, b_fault}); end
  endtask

  task automatic test_ack_at_expiry;
    b_cyc = 1'b1; b_stb = 1'b1; b_adr = 32'h0000_5000;
    tick();
    for (int k = 1; k <= 8; k++) begin
      n_cmp++;
      if ({b_s_stb, b_err} !== {16'h0020, 1'b0}) begin
        n_bad++; $display("FAIL expiry_busy_c%0d: got stb=%h err=%b want stb=0020 err=0", k, b_s_stb, b_err);
      end
      tick();
    end
    b_s_ack = 16'h0020;
    #1;
    n_cmp++; if ({b_ack, b_err} !== 2'b10) begin n_bad++; $display("FAIL expiry_c9_ack: got %b want 10", {b_ack, b_err}); end
    tick();
    b_s_ack = 16'h0000; b_cyc = 1'b0; b_stb = 1'b0;
    #1;
    n_cmp++; if ({b_err, b_fault, b_s_stb} !== 18'h0) begin n_bad++; $display("FAIL expiry_no_fault: got %h want 0", {b_err, b_fault, b_s_stb}); end
    n_cmp++; if (b_fcode !== 2'b10) begin n_bad++; $display("FAIL expiry_code_unchanged: got %b want 10", b_fcode); end
  endtask

  task automatic test_write;
    b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b1; b_adr = 32'h0000_8004;
    b_sel = 4'b0011; b_wdat = 32'hCAFE_F00D;
    #1;
    n_cmp++; if ({b_s_we, b_s_sel} !== 5'b1_0011) begin n_bad++; $display("FAIL write_we_sel: got %b want 10011", {b_s_we, b_s_sel}); end
    n_cmp++; if (b_s_dat_o !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL write_dat: got %h want cafef00d", b_s_dat_o); end
    n_cmp++; if (b_s_adr !== 32'h0000_8004) begin n_bad++; $display("FAIL write_adr: got %h want 00008004", b_s_adr); end
    tick();
    n_cmp++; if ({b_s_cyc, b_s_stb} !== {16'h0100, 16'h0100}) begin n_bad++; $display("FAIL write_c1_port8: got cyc=%h stb=%h want 0100", b_s_cyc, b_s_stb); end
    tick();
    b_s_ack = 16'h0100;
    #1;
    n_cmp++; if (b_ack !== 1'b1) begin n_bad++; $display("FAIL write_c2_ack: got %b want 1", b_ack); end
    tick();
    b_s_ack = 16'h0000; b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0;
    #1;
    n_cmp++; if (b_s_stb !== 16'h0000) begin n_bad++; $display("FAIL write_c3_idle: got %h want 0000", b_s_stb); end
  endtask

  task automatic test_reset_mid_access;
    a_cyc = 1'b1; a_stb = 1'b1; a_adr = 32'h2000_0000;
    tick();
    a_s_ack = 16'h0004;
    #1;
    n_cmp++; if ({a_s_stb, a_ack} !== {16'h0004, 1'b1}) begin n_bad++; $display("FAIL rstmid_busy: got stb=%h ack=%b want 0004/1", a_s_stb, a_ack); end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({a_s_cyc, a_s_stb} !== 32'h0) begin n_bad++; $display("FAIL rstmid_strobes: got %h want 0", {a_s_cyc, a_s_stb}); end
    n_cmp++; if ({a_ack, a_err} !== 2'b00) begin n_bad++; $display("FAIL rstmid_ack_err: got %b want 00", {a_ack, a_err}); end
    n_cmp++; if (b_fcode !== 2'b00) begin n_bad++; $display("FAIL rstmid_b_code_clear: got %b want 00", b_fcode); end
    a_s_ack = 16'h0000; a_cyc = 1'b0; a_stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    a_cyc = 1'b1; a_stb = 1'b1; a_adr = 32'h3000_0000;
    tick();
    n_cmp++; if (a_s_stb !== 16'h0008) begin n_bad++; $display("FAIL rstmid_after_decode: got %h want 0008", a_s_stb); end
    tick();
    a_s_ack = 16'h0008;
    #1;
    n_cmp++; if ({a_ack, a_rdat} !== {1'b1, 32'hD000_0003}) begin n_bad++; $display("FAIL rstmid_after_ack: got ack=%b dat=%h want 1/d0000003", a_ack, a_rdat); end
    tick();
    a_s_ack = 16'h0000; a_cyc = 1'b0; a_stb = 1'b0;
    #1;
  endtask

  initial begin
    a_cyc = 1'b0; a_stb = 1'b0; a_we = 1'b0; a_adr = '0; a_sel = '0; a_wdat = '0; a_s_ack = '0;
    b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0; b_adr = '0; b_sel = '0; b_wdat = '0; b_s_ack = '0;
    b_s_dat_i = '0;
    for (int i = 0; i < 16; i++) a_s_dat_i[i*32 +: 32] = 32'hD000_0000 | 32'(i);
    test_reset();
    test_read_default();
    test_unmapped();
    test_timeout();
    test_ack_at_expiry();
    test_write();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
